karatsuba_seq_mult: RTL and testbench

//  Parametrised, multi-cycle Karatsuba multiplier with valid/ready handshakes and a per-operation signed/unsigned mode.

---
 rtl/karatsuba_seq_mult.sv | 138 +++++++++++++
 tb/tb_karatsuba_seq_mult.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_mult.sv
// Multi-cycle Karatsuba multiplier. One (WIDTH/2+1)-bit sub-multiplier is shared across
// three partial products. FSM states are IDLE, LL (z0), HH (z2), MID (z1), COMB (recombine) and DONE (hold P).
module karatsuba_seq_mult #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int H  = WIDTH / 2;
  localparam int SW = H + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_HH   = 3'd2,
    S_MID  = 3'd3,
    S_COMB = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     z0_q, z0_d;
  logic [WIDTH-1:0]     z2_q, z2_d;
  logic [WIDTH+1:0]     z1_q, z1_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [SW-1:0]        a_sum, b_sum;
  logic [SW-1:0]        mul_a, mul_b;
  logic [2*SW-1:0]      mul_p;
  logic [WIDTH+1:0]     m_mid;
  logic [2*WIDTH-1:0]   p_mag;

  // The most negative input negates to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign a_mag = (in_signed && A[WIDTH-1]) ? (-A) : A;
  assign b_mag = (in_signed && B[WIDTH-1]) ? (-B) : B;

  assign a_sum = {1'b0, a_q[H-1:0]} + {1'b0, a_q[WIDTH-1:H]};
  assign b_sum = {1'b0, b_q[H-1:0]} + {1'b0, b_q[WIDTH-1:H]};

  assign mul_p = {{SW{1'b0}}, mul_a} * {{SW{1'b0}}, mul_b};

  assign m_mid = z1_q - {2'b00, z2_q} - {2'b00, z0_q};
  assign p_mag = {z2_q, {WIDTH{1'b0}}}
               + ({{(WIDTH-2){1'b0}}, m_mid} << H)
               + {{WIDTH{1'b0}}, z0_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      z0_q    <= '0;
      z2_q    <= '0;
      z1_q    <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      z1_q    <= z1_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    z0_d      = z0_q;
    z2_d      = z2_q;
    z1_d      = z1_q;
    p_d       = p_q;
    mul_a     = '0;
    mul_b     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          state_d = S_LL;
        end
      end
      S_LL: begin
        mul_a   = {1'b0, a_q[H-1:0]};
        mul_b   = {1'b0, b_q[H-1:0]};
        z0_d    = mul_p[WIDTH-1:0];
        state_d = S_HH;
      end
      S_HH: begin
        mul_a   = {1'b0, a_q[WIDTH-1:H]};
        mul_b   = {1'b0, b_q[WIDTH-1:H]};
        z2_d    = mul_p[WIDTH-1:0];
        state_d = S_MID;
      end
      S_MID: begin
        mul_a   = a_sum;
        mul_b   = b_sum;
        z1_d    = mul_p;
        state_d = S_COMB;
      end
      S_COMB: begin
        // Negating a zero magnitude yields zero, so no negative-zero special case is needed.
        p_d     = neg_q ? (-p_mag) : p_mag;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign P = p_q;

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Directed plus random bench for karatsuba_seq_mult. Expected products are queued at the
// input handshake and checked by a monitor at the output handshake.
module tb_karatsuba_seq_mult;

  localparam int WIDTH = 64;
  localparam int PW    = 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    P;

  logic [PW-1:0]    exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic             rand_ready = 1'b0;

  karatsuba_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic s);
    logic signed [PW-1:0] sa, sb;
    logic [PW-1:0]        ua, ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = {{WIDTH{1'b0}}, a};
    ub = {{WIDTH{1'b0}}, b};
    return ua * ub;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_operand();
    logic [127:0]     wide;
    logic [WIDTH-1:0] v;
    wide = {$urandom, $urandom, $urandom, $urandom};
    v    = wide[WIDTH-1:0];
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = {1'b1, {(WIDTH-1){1'b0}}};
      2: v = '0;
      3: v = {1'b0, {(WIDTH-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  // Output-side scoreboard: compare on every cycle where the output handshake will occur.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_out observed=%0h expected=none", P);
      end
      if (exp_q.size() != 0) check("product", P, exp_q.pop_front());
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                      input logic [PW-1:0] expv);
    int cyc;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    in_signed = s;
    cyc       = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cyc++;
      if (cyc > 100) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("drain", PW'(exp_q.size()), 0);
  endtask

  initial begin
    logic [PW-1:0]    e;
    logic [PW-1:0]    held;
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    int               k;

    void'($urandom(32'd20240611));
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    A         = '0;
    B         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_P", P, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All-ones unsigned square; out_valid appears 4 edges after the accepting edge (5 counting it).
    e = {{(WIDTH-1){1'b1}}, 1'b0, {(WIDTH-1){1'b0}}, 1'b1};
    send('1, '1, 1'b0, e);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("latency", PW'(k), 4);
    drain();

    send('1, '1, 1'b1, PW'(1));
    drain();
    e = {2'b01, {(PW-2){1'b0}}};
    send({1'b1, {(WIDTH-1){1'b0}}}, {1'b1, {(WIDTH-1){1'b0}}}, 1'b1, e);
    drain();
    e = '0;
    e = e - PW'(21);
    send(-WIDTH'(3), WIDTH'(7), 1'b1, e);
    drain();
    send('0, -WIDTH'(5), 1'b1, '0);
    drain();

    // Backpressure: result and handshake signals frozen while the consumer stalls.
    out_ready = 1'b0;
    send(WIDTH'(123456789), WIDTH'(987654321), 1'b0, golden(WIDTH'(123456789), WIDTH'(987654321), 1'b0));
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("bp_latency", PW'(k), 4);
    held = P;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_P_stable", P, held);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_drained", PW'(exp_q.size()), 0);

    // Asynchronous reset while in MID aborts the operation.
    send(WIDTH'(7), WIDTH'(9), 1'b0, golden(WIDTH'(7), WIDTH'(9), 1'b0));
    @(posedge clk);
    @(posedge clk);
    #3;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_P", P, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(WIDTH'(3), WIDTH'(5), 1'b0, PW'(15));
    drain();

    // Junk presented while busy must be ignored.
    send(WIDTH'(11), -WIDTH'(13), 1'b1, golden(WIDTH'(11), -WIDTH'(13), 1'b1));
    for (int i = 0; i < 3; i++) begin
      in_valid  = ~in_valid;
      A         = rnd_operand();
      B         = rnd_operand();
      in_signed = ~in_signed;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("ignored_no_extra", PW'(exp_q.size()), 0);

    rand_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      ra = rnd_operand();
      rb = rnd_operand();
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, golden(ra, rb, rs));
      drain();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
